lfsr_checker: RTL and testbench

- Receive side of the LFSR pseudo-random generator: consumes the serial bit stream the generator produces (its feedback bit, one per valid beat).
- Self-synchronises a local copy of the generator register, declares lock, then counts bit errors and detects loss of sync.
- Sits at the end of a link or loopback under test, beside the generator. Used for built-in self-test of data paths and memories.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_predict.sv | 21 ++
 rtl/lfsr_checker.sv | 136 +++++++++++++
 tb/tb_lfsr_checker.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator/checker pair: feedback tap offsets
// (measured down from the top bit) and the checker synchronisation state.
package lfsr_pkg;

  localparam int TAP_A = 1;
  localparam int TAP_B = 3;
  localparam int TAP_C = 4;
  localparam int TAP_D = 6;
  localparam int TAP_E = 10;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

  // Bits needed to hold any value from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Next-bit function of the LFSR: XNOR of the tap bits of an N-bit register.
// Shared by generator and checker so the tap set lives in exactly one place.
module lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] state,
  output logic         predicted
);

  // Masked reduction keeps every state bit formally used.
  localparam logic [N-1:0] TAP_MASK = (N'(1) << (N - TAP_A))
                                    | (N'(1) << (N - TAP_B))
                                    | (N'(1) << (N - TAP_C))
                                    | (N'(1) << (N - TAP_D))
                                    | (N'(1) << (N - TAP_E));

  assign predicted = ~(^(state & TAP_MASK));

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises a local LFSR copy to the incoming
// stream, declares lock, then counts bit errors and detects loss of sync.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int N        = 64,
  parameter int LOCK_LEN = 32,
  parameter int LOSS_LEN = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W  = cnt_width(N);
  localparam int MATCH_W = cnt_width(LOCK_LEN);
  localparam int MISS_W  = cnt_width(LOSS_LEN);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(N);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_LEN);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  logic [N-1:0]       s_q, s_d;
  chk_state_e         state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic               predicted;
  logic               mismatch;
  logic [MATCH_W-1:0] match_inc;
  logic [MISS_W-1:0]  miss_inc;

  lfsr_predict #(
    .N(N)
  ) u_predict (
    .state     (s_q),
    .predicted (predicted)
  );

  assign mismatch  = in_bit ^ predicted;
  assign match_inc = match_q + MATCH_W'(1);
  assign miss_inc  = miss_q + MISS_W'(1);

  always_comb begin
    s_d         = s_q;
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      unique case (state_q)
        ST_SEARCH: begin
          s_d = {s_q[N-2:0], in_bit};
          // The register must hold N genuine stream bits before predictions mean anything.
          if (fill_q != FILL_LAST) begin
            fill_d = fill_q + FILL_W'(1);
          end else if (mismatch) begin
            match_d = '0;
          end else if (match_inc == MATCH_LAST) begin
            state_d = ST_LOCKED;
            match_d = '0;
            miss_d  = '0;
          end else begin
            match_d = match_inc;
          end
        end

        ST_LOCKED: begin
          // Free-run on our own prediction so a channel error cannot corrupt the register.
          s_d = {s_q[N-2:0], predicted};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            if (miss_inc == MISS_LAST) begin
              state_d = ST_SEARCH;
              fill_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: state_d = ST_SEARCH;
      endcase
    end

    // Clear wins over a coincident increment; the error strobe is unaffected.
    if (clear) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q         <= '1;
      state_q     <= ST_SEARCH;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      s_q         <= s_d;
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (16-bit and 4-bit error counters) share
// stimulus and are compared each cycle against a sequence-level reference model.
module tb_lfsr_checker;

  localparam int N        = 64;
  localparam int LOCK_LEN = 32;
  localparam int LOSS_LEN = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic clear = 1'b0;

  logic        locked_a, err_pulse_a;
  logic [15:0] err_count_a;
  logic        locked_b, err_pulse_b;
  logic [3:0]  err_count_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: stream history of generator and of checker's local register.
  bit gen_seq[$];
  bit loc_seq[$];
  bit m_locked, m_pulse;
  int m_fill, m_run, m_miss, m_cnt16, m_cnt4;

  logic [37:0] got, exp;

  always #5 clk = ~clk;

  lfsr_checker #(.N(N), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a)
  );

  lfsr_checker #(.N(N), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN), .CNT_W(4)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b)
  );

  // History index below zero is the all-ones reset content.
  function automatic bit gen_get(input int i);
    return (i < 0) ? 1'b1 : gen_seq[i];
  endfunction

  function automatic bit loc_get(input int i);
    return (i < 0) ? 1'b1 : loc_seq[i];
  endfunction

  // Bit t of the stream depends on bits t-N, t-N+2, t-N+3, t-N+5, t-N+9.
  function automatic bit gen_next();
    int t;
    bit b;
    t = gen_seq.size();
    b = ~(gen_get(t-N) ^ gen_get(t-N+2) ^ gen_get(t-N+3) ^ gen_get(t-N+5) ^ gen_get(t-N+9));
    gen_seq.push_back(b);
    return b;
  endfunction

  function automatic bit loc_pred();
    int t;
    t = loc_seq.size();
    return ~(loc_get(t-N) ^ loc_get(t-N+2) ^ loc_get(t-N+3) ^ loc_get(t-N+5) ^ loc_get(t-N+9));
  endfunction

  function automatic void model_reset();
    loc_seq.delete();
    m_locked = 0; m_pulse = 0;
    m_fill = 0; m_run = 0; m_miss = 0; m_cnt16 = 0; m_cnt4 = 0;
  endfunction

  function automatic void model_cycle(input bit v, input bit b, input bit clr);
    bit p;
    m_pulse = 0;
    if (v) begin
      p = loc_pred();
      if (!m_locked) begin
        loc_seq.push_back(b);
        if (m_fill < N) m_fill++;
        else if (b != p) m_run = 0;
        else begin
          m_run++;
          if (m_run == LOCK_LEN) begin m_locked = 1; m_run = 0; m_miss = 0; end
        end
      end else begin
        loc_seq.push_back(p);
        if (b != p) begin
          m_pulse = 1;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
          m_miss++;
          if (m_miss == LOSS_LEN) begin m_locked = 0; m_fill = 0; m_run = 0; m_miss = 0; end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (clr) begin m_cnt16 = 0; m_cnt4 = 0; end
  endfunction

  task automatic step(input bit v, input bit b, input bit clr);
    in_valid = v; in_bit = b; clear = clr;
    @(posedge clk);
    model_cycle(v, b, clr);
    #1;
    got = {locked_a, err_pulse_a, err_count_a, locked_b, err_pulse_b, err_count_b};
    exp = {m_locked, m_pulse, 16'(m_cnt16), m_locked, m_pulse, 4'(m_cnt4)};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({locked_a, err_pulse_a, err_count_a, locked_b, err_pulse_b, err_count_b} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", {locked_a, err_pulse_a, err_count_a, locked_b, err_pulse_b, err_count_b});
    end
    reset_n = 1'b1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_lock_acquire();
    int lock_beat;
    lock_beat = 0;
    gen_seq.delete();
    for (int i = 1; i <= 2000; i++) begin
      step(1'b1, gen_next(), 1'b0);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL lock_model beat %0d: got %h want %h", i, got, exp);
      end
      if (lock_beat == 0 && locked_a === 1'b1) lock_beat = i;
    end
    n_tests++;
    if (lock_beat != N + LOCK_LEN) begin
      n_fail++;
      $display("FAIL lock_beat: got %0d want %0d", lock_beat, N + LOCK_LEN);
    end
    n_tests++;
    if (err_count_a !== 16'd0) begin
      n_fail++;
      $display("FAIL lock_clean_count: got %0d want 0", err_count_a);
    end
    $display("[TB] test_lock_acquire: locked at beat %0d", lock_beat);
  endtask

  task automatic test_single_flip();
    bit b;
    for (int i = 1; i <= 1300; i++) begin
      b = gen_next();
      step(1'b1, (i == 300) ? ~b : b, 1'b0);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL flip_model beat %0d: got %h want %h", i, got, exp);
      end
      if (i == 299 || i == 300 || i == 301) begin
        n_tests++;
        if (err_pulse_a !== (i == 300)) begin
          n_fail++;
          $display("FAIL flip_pulse beat %0d: got %b want %b", i, err_pulse_a, (i == 300));
        end
      end
    end
    n_tests++;
    if (err_count_a !== 16'd1 || locked_a !== 1'b1) begin
      n_fail++;
      $display("FAIL flip_final: count %0d locked %b want 1 1", err_count_a, locked_a);
    end
    $display("[TB] test_single_flip: err_count %0d", err_count_a);
  endtask

  task automatic test_gapped();
    int vb, lock_vb;
    bit v;
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #2 reset_n = 1'b1;
    gen_seq.delete();
    vb = 0; lock_vb = 0;
    for (int c = 0; c < 3000 && vb < 400; c++) begin
      v = 1'($urandom_range(0, 1));
      if (v) vb++;
      step(v, v ? gen_next() : 1'($urandom_range(0, 1)), 1'b0);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL gapped_model cycle %0d: got %h want %h", c, got, exp);
      end
      if (!v) begin
        n_tests++;
        if (err_pulse_a !== 1'b0) begin
          n_fail++;
          $display("FAIL gapped_idle_pulse cycle %0d: got %b want 0", c, err_pulse_a);
        end
      end
      if (lock_vb == 0 && locked_a === 1'b1) lock_vb = vb;
    end
    n_tests++;
    if (lock_vb != N + LOCK_LEN) begin
      n_fail++;
      $display("FAIL gapped_lock_beat: got %0d want %0d", lock_vb, N + LOCK_LEN);
    end
    $display("[TB] test_gapped: locked at valid beat %0d", lock_vb);
  endtask

  task automatic relock(input string tag);
    int beats;
    beats = 0;
    while (locked_a !== 1'b1 && beats < 500) begin
      beats++;
      step(1'b1, gen_next(), 1'b0);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s_relock_model beat %0d: got %h want %h", tag, beats, got, exp);
      end
    end
    n_tests++;
    if (beats != N + LOCK_LEN) begin
      n_fail++;
      $display("FAIL %s_relock_beats: got %0d want %0d", tag, beats, N + LOCK_LEN);
    end
    $display("[TB] %s relocked after %0d beats", tag, beats);
  endtask

  task automatic test_loss_of_sync();
    int beats;
    step(1'b0, 1'b0, 1'b1);
    // Constant-one input: errors only where the prediction is zero.
    beats = 0;
    while (locked_a === 1'b1 && beats < 8000) begin
      beats++;
      step(1'b1, 1'b1, 1'b0);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL loss_const_model beat %0d: got %h want %h", beats, got, exp);
      end
    end
    n_tests++;
    if (locked_a !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_const_unlock: locked %b after %0d beats want 0", locked_a, beats);
    end
    relock("loss_const");
    // Inverted stream: every beat mismatches, so exactly LOSS_LEN beats to unlock.
    step(1'b0, 1'b0, 1'b1);
    beats = 0;
    while (locked_a === 1'b1 && beats < 50) begin
      beats++;
      step(1'b1, ~gen_next(), 1'b0);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL loss_inv_model beat %0d: got %h want %h", beats, got, exp);
      end
    end
    n_tests++;
    if (beats != LOSS_LEN || err_count_a !== 16'(LOSS_LEN) || locked_a !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_inv: beats %0d count %0d locked %b want %0d %0d 0", beats, err_count_a, locked_a, LOSS_LEN, LOSS_LEN);
    end
    relock("loss_inv");
  endtask

  task automatic test_saturation_clear();
    bit b;
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 21; k++) begin
      for (int j = 0; j < 50; j++) begin
        b = gen_next();
        step(1'b1, (j == 49) ? ~b : b, (k == 21 && j == 49));
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL sat_model flip %0d beat %0d: got %h want %h", k, j, got, exp);
        end
      end
      if (k == 20) begin
        n_tests++;
        if (err_count_b !== 4'd15 || err_count_a !== 16'd20 || locked_b !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_count: cnt4 %0d cnt16 %0d locked %b want 15 20 1", err_count_b, err_count_a, locked_b);
        end
      end
    end
    n_tests++;
    if (err_count_a !== 16'd0 || err_count_b !== 4'd0 || err_pulse_a !== 1'b1 || err_pulse_b !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_with_error: cnt16 %0d cnt4 %0d pulse %b%b want 0 0 11", err_count_a, err_count_b, err_pulse_a, err_pulse_b);
    end
    $display("[TB] test_saturation_clear done");
  endtask

  task automatic test_reset_midlock();
    bit b;
    b = gen_next();
    step(1'b1, ~b, 1'b0);
    step(1'b1, gen_next(), 1'b0);
    n_tests++;
    if (got !== exp || err_count_a !== 16'd1) begin
      n_fail++;
      $display("FAIL midlock_pre: got %h want %h", got, exp);
    end
    in_valid = 1'b1; in_bit = ~gen_next();
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({locked_a, err_pulse_a, err_count_a, locked_b, err_pulse_b, err_count_b} !== 38'd0) begin
      n_fail++;
      $display("FAIL midlock_async_reset: got %h want 0", {locked_a, err_pulse_a, err_count_a, locked_b, err_pulse_b, err_count_b});
    end
    #2 reset_n = 1'b1;
    relock("midlock");
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_single_flip();
    test_gapped();
    test_loss_of_sync();
    test_saturation_clear();
    test_reset_midlock();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
